rsa_xcel_modexp_param: RTL and testbench
========================================

# rsa_xcel_modexp_param

Parametrised modular-exponentiation unit computing b^e mod n for p_nbits-wide operands using right-to-left square-and-multiply. It time-shares one sequential shift-add modular multiplier in place of dedicated multiply/remainder units, and it defines behaviour for operands ≥ n and for degenerate moduli. It sits behind the RSA accelerator's request stream as a drop-in, width-generic replacement for the fixed 32-bit exponentiation block.

## Interface
- p_nbits, 32, operand/result width; must be ≥ 2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- istream_msg  in  3*p_nbits  {n, e, b}; b in [p_nbits-1:0], e in [2*p_nbits-1:p_nbits], n in top field
- istream_val  in  1  request valid
- istream_rdy  out  1  request ready
- ostream_msg  out  p_nbits  result r = b^e mod n
- ostream_val  out  1  result valid
- ostream_rdy  in  1  result ready

## Operation
- Registers: b_reg, e_reg, n_reg, r_reg, iteration counter iter (clog2(p_nbits+1) bits).
- Modular multiply mulmod(a, x, n): requires a < n; x is unrestricted.
  - MSB-first over the bits of x: acc = 2*acc + (x bit ? a : 0), then subtract n at most twice.
  - acc is p_nbits+2 bits wide.
  - Takes exactly p_nbits cycles.
- States:
  - IDLE: istream_rdy=1. On handshake, latch b, e and n, and set r_reg=1 and iter=0.
    - If n≤1, set r_reg=0 and go to DONE.
    - Otherwise go to REDUCE.
  - REDUCE: b_reg = mulmod(1, b, n), which gives b mod n. Then go to STEP.
  - STEP (1 cycle):
    - If the termination condition holds, go to DONE.
    - Else if e_reg[0]=1, go to MUL.
    - Else go to SQR.
  - MUL: r_reg = mulmod(r_reg, b_reg, n), then go to SQR.
  - SQR: b_reg = mulmod(b_reg, b_reg, n); then e_reg >>= 1 and iter++. Then go to STEP.
  - DONE: ostream_val=1 and ostream_msg=r_reg. On ostream_rdy, go to IDLE.
- Termination condition: iter == p_nbits (see Configuration for the early-exit variant).
- e=0 with n≥2 yields 1. Any b with n≤1 yields 0.
- istream_rdy=0 in every state except IDLE, so there is no overlap between requests.

## Timing
- Reset (asynchronous): state=IDLE, all registers 0, ostream_val=0, ostream_msg=0. istream_rdy=0 while reset is high.
- Reset asserted mid-operation aborts the computation immediately and produces no output. The first request after reset deasserts is accepted normally.
- Let W=p_nbits. With acceptance in cycle 0, ostream_val first rises in cycle L:
  - L = W + 2 + Σ over executed iterations (W·(1+e_i) + 1).
  - n≤1: L = 1.
- ostream_msg is held stable while ostream_val && !ostream_rdy.
- DONE→IDLE takes 1 cycle, so a new request can be accepted no earlier than the cycle after the output handshake.
- istream_val while busy is ignored and the message is not consumed.

## Configuration
- RSA_XCEL_MODEXP_EARLY_EXIT_EN
  - Defined: STEP also terminates when e_reg == 0, so the iteration count is floor(log2 e)+1 (0 for e=0). Latency depends on the data.
  - Undefined: always exactly W iterations, giving constant time for a given popcount(e).
  - Results are identical in both builds.

## Structure
- Package rsa_xcel_modexp_pkg holds:
  - the state enum typedef (IDLE, REDUCE, STEP, MUL, SQR, DONE);
  - field-offset localparams for istream_msg unpacking.
- Sub-module rsa_xcel_modexp_mulmod, parameter p_nbits:
  - ports: clk, reset, start, a, x, n, busy, done (1-cycle pulse), result;
  - latency W cycles from start.
- The parent FSM owns all registers outside the multiplier.

## Test plan
- b=4, e=13, n=497 → 445. Without the macro, L = 34 + 1056 + 32·3 = 1186.
- b=2, e=10, n=1000 → 24.
- b=1000, e=1, n=7 → 6 (exercises b ≥ n reduction). With the macro, L = 99.
- e=0, n=7 → 1; n=1 → 0; n=0 → 0. For n≤1, L = 1.
- Sequence of 2 back-to-back requests with ostream_rdy held low for 10 cycles:
  - ostream_msg is stable throughout;
  - istream_rdy stays 0 until the cycle after the output handshake.
- Reset pulsed mid-MUL:
  - ostream_val stays 0 and all outputs clear immediately;
  - the next request (b=3, e=5, n=13) → 9.

Source files
------------

// File: rtl/rsa_xcel_modexp_pkg.sv
// rsa_xcel_modexp_pkg: FSM state encoding and request-message field indices
package rsa_xcel_modexp_pkg;
  typedef enum logic [2:0] {IDLE, REDUCE, STEP, MUL, SQR, DONE} state_t;
  // Field offset within istream_msg is field * p_nbits.
  localparam int b_field = 0;
  localparam int e_field = 1;
  localparam int n_field = 2;
endpackage

// File: rtl/rsa_xcel_modexp_param_if.sv
// rsa_xcel_modexp_param_if: request {n,e,b} and result streams with val/rdy handshakes
interface rsa_xcel_modexp_param_if #(parameter int p_nbits = 32);
  logic [3*p_nbits-1:0] istream_msg;
  logic istream_val;
  logic istream_rdy;
  logic [p_nbits-1:0] ostream_msg;
  logic ostream_val;
  logic ostream_rdy;
  modport master(output istream_msg, istream_val, ostream_rdy, input istream_rdy, ostream_msg, ostream_val);
  modport slave(input istream_msg, istream_val, ostream_rdy, output istream_rdy, ostream_msg, ostream_val);
endinterface

// File: rtl/rsa_xcel_modexp_mulmod.sv
// rsa_xcel_modexp_mulmod: sequential shift-add a*x mod n (a < n), p_nbits cycles from start
// Ports: start launches; operands a, x, n must stay stable until done; done pulses in
// the last cycle with result valid alongside it; busy covers the cycles after start.
module rsa_xcel_modexp_mulmod #(parameter int p_nbits = 32) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [p_nbits-1:0] a,
  input  logic [p_nbits-1:0] x,
  input  logic [p_nbits-1:0] n,
  output logic busy,
  output logic done,
  output logic [p_nbits-1:0] result
);
  localparam int cw = $clog2(p_nbits);
  logic [p_nbits+1:0] acc, acc_in, t, s1, s2, nn;
  logic [cw-1:0] cnt, idx;
  // The start cycle already processes the top bit of x, so the final bit is
  // folded combinationally and the result is ready in cycle p_nbits.
  always_comb begin
    idx = start ? cw'(p_nbits - 1) : cnt;
    acc_in = start ? '0 : acc;
    nn = {2'b0, n};
    t = (acc_in << 1) + (x[idx] ? {2'b0, a} : '0);
    s1 = t >= nn ? t - nn : t;
    s2 = s1 >= nn ? s1 - nn : s1;
  end
  assign done = (start || busy) && idx == '0;
  assign result = s2[p_nbits-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc <= s2;
      cnt <= cw'(p_nbits - 2);
      busy <= 1'b1;
    end else if (busy) begin
      acc <= s2;
      cnt <= cnt - 1'b1;
      busy <= cnt != '0;
    end
endmodule

// File: rtl/rsa_xcel_modexp_param.sv
// rsa_xcel_modexp_param: b^e mod n by right-to-left square-and-multiply on one shared mulmod
// Ports: clk, reset (async, active-high), io (slave): istream {n,e,b} in, ostream r out.
// RSA_XCEL_MODEXP_EARLY_EXIT_EN: stop iterating once the exponent is exhausted.
module rsa_xcel_modexp_param import rsa_xcel_modexp_pkg::*; #(parameter int p_nbits = 32) (
  input logic clk,
  input logic reset,
  rsa_xcel_modexp_param_if.slave io
);
  localparam int iw = $clog2(p_nbits + 1);
  state_t state;
  logic [p_nbits-1:0] b_reg, e_reg, n_reg, r_reg, mm_a, mm_result, in_b, in_e, in_n, out_msg;
  logic [iw-1:0] iter;
  logic start, mm_busy, mm_done, term, out_val;
  assign in_b = io.istream_msg[b_field*p_nbits +: p_nbits];
  assign in_e = io.istream_msg[e_field*p_nbits +: p_nbits];
  assign in_n = io.istream_msg[n_field*p_nbits +: p_nbits];
  // x is always b_reg: REDUCE is 1*b, MUL is r*b, SQR is b*b.
  assign mm_a = state == MUL ? r_reg : state == SQR ? b_reg : p_nbits'(1);
`ifdef RSA_XCEL_MODEXP_EARLY_EXIT_EN
  assign term = iter == iw'(p_nbits) || e_reg == '0;
`else
  assign term = iter == iw'(p_nbits);
`endif
  assign io.istream_rdy = state == IDLE && !mm_busy && !reset;
  assign io.ostream_val = out_val;
  assign io.ostream_msg = out_msg;
  rsa_xcel_modexp_mulmod #(.p_nbits(p_nbits)) u_mulmod (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(mm_a),
    .x(b_reg),
    .n(n_reg),
    .busy(mm_busy),
    .done(mm_done),
    .result(mm_result)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      b_reg <= '0;
      e_reg <= '0;
      n_reg <= '0;
      r_reg <= '0;
      iter <= '0;
      start <= 1'b0;
      out_val <= 1'b0;
      out_msg <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE:
          if (io.istream_val && io.istream_rdy) begin
            b_reg <= in_b;
            e_reg <= in_e;
            n_reg <= in_n;
            iter <= '0;
            if (in_n <= p_nbits'(1)) begin
              r_reg <= '0;
              out_msg <= '0;
              out_val <= 1'b1;
              state <= DONE;
            end else begin
              r_reg <= p_nbits'(1);
              start <= 1'b1;
              state <= REDUCE;
            end
          end
        REDUCE:
          if (mm_done) begin
            b_reg <= mm_result;
            state <= STEP;
          end
        STEP:
          if (term) begin
            out_msg <= r_reg;
            out_val <= 1'b1;
            state <= DONE;
          end else begin
            start <= 1'b1;
            state <= e_reg[0] ? MUL : SQR;
          end
        MUL:
          if (mm_done) begin
            r_reg <= mm_result;
            start <= 1'b1;
            state <= SQR;
          end
        SQR:
          if (mm_done) begin
            b_reg <= mm_result;
            e_reg <= e_reg >> 1;
            iter <= iter + 1'b1;
            state <= STEP;
          end
        DONE:
          if (io.ostream_rdy) begin
            out_val <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rsa_xcel_modexp_param.sv
// tb_rsa_xcel_modexp_param: scoreboard bench with directed vectors for rsa_xcel_modexp_param
module tb_rsa_xcel_modexp_param;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rsa_xcel_modexp_param_if #(.p_nbits(W)) io();
  rsa_xcel_modexp_param #(.p_nbits(W)) dut(.clk(clk), .reset(reset), .io(io));
  typedef struct { logic [W-1:0] r; int acc; int lat; } exp_t;
  exp_t q[$];
  exp_t cur;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit pv = 0;
  bit hs = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int exp_lat(logic [W-1:0] e, logic [W-1:0] n);
    int it, l;
    if (n <= 1) return 1;
    it = W;
`ifdef RSA_XCEL_MODEXP_EARLY_EXIT_EN
    it = 0;
    for (int i = 0; i < W; i++) if (e[i]) it = i + 1;
`endif
    l = W + 2;
    for (int i = 0; i < it; i++) l += W * (1 + int'(e[i])) + 1;
    return l;
  endfunction

  task automatic send(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] n, logic [W-1:0] r);
    int k = 0;
    @(negedge clk);
    io.istream_msg = {n, e, b};
    io.istream_val = 1'b1;
    while (!io.istream_rdy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!io.istream_rdy) begin
      fail_now("accept_timeout");
      io.istream_val = 1'b0;
      return;
    end
    q.push_back('{r, cyc, exp_lat(e, n)});
    @(posedge clk);
    #1 io.istream_val = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || io.ostream_val) && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (k == 10000) fail_now("drain_timeout");
  endtask

  task automatic stall_release();
    int k = 0;
    while (!io.ostream_val && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!io.ostream_val) fail_now("stall_wait_timeout");
    repeat (10) @(posedge clk);
    #1 io.ostream_rdy = 1'b1;
    @(posedge clk);
    #1 io.ostream_rdy = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      pv = 0;
      hs = 0;
    end else begin
      if (hs) check("istream_rdy_after_handshake", io.istream_rdy, 1);
      hs = 0;
      if (io.ostream_val) begin
        if (!pv) begin
          if (q.size() == 0) fail_now("unexpected_output");
          else begin
            cur = q.pop_front();
            check("latency", cyc - cur.acc, cur.lat);
          end
        end
        check("result", io.ostream_msg, cur.r);
        check("istream_rdy_while_done", io.istream_rdy, 0);
        hs = io.ostream_rdy;
      end
      pv = io.ostream_val;
    end
  end

  initial begin
    io.istream_val = 1'b0;
    io.istream_msg = '0;
    io.ostream_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_istream_rdy", io.istream_rdy, 0);
    check("reset_ostream_val", io.ostream_val, 0);
    check("reset_ostream_msg", io.ostream_msg, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_istream_rdy", io.istream_rdy, 1);
    send(4, 13, 497, 445);
    send(2, 10, 1000, 24);
    send(1000, 1, 7, 6);
    send(5, 0, 7, 1);
    send(5, 3, 1, 0);
    send(9, 3, 0, 0);
    send(0, 3, 5, 0);
    send(32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 0);
    send(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    send(7, 2, 10, 9);
    drain();
    io.ostream_rdy = 1'b0;
    fork
      begin
        send(3, 5, 13, 9);
        send(2, 10, 1000, 24);
      end
      begin
        stall_release();
        stall_release();
      end
    join
    io.ostream_rdy = 1'b1;
    drain();
    send(5, 7, 11, 3);
    repeat (40) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_ostream_val", io.ostream_val, 0);
    check("midrun_reset_ostream_msg", io.ostream_msg, 0);
    check("midrun_reset_istream_rdy", io.istream_rdy, 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(3, 5, 13, 9);
    drain();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
